// File: rtl/motor_access_ctrl_pkg.sv
// Shared types, timing defaults and helpers for the motor code-lock controller.
// State encodings double as the display status code.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DENY  = 3'd3,
    ST_ERR   = 3'd4,
    ST_LOCK  = 3'd5
  } state_e;

  localparam int unsigned DEF_CNT_W = 24;
  localparam logic [4:0]  DEF_KEY   = 5'b10101;

  localparam logic [23:0] DEF_RUN_CYCLES  = 24'd1_000_000;
  localparam logic [23:0] DEF_DENY_CYCLES = 24'd100_000;
  localparam logic [23:0] DEF_LOCK_CYCLES = 24'd5_000_000;
  localparam logic [1:0]  DEF_MAX_FAILS   = 2'd3;

  function automatic logic is_3of5(logic [4:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n == 3'd3;
  endfunction

endpackage

// File: rtl/motor_access_ctrl_if.sv
// Switch/button inputs and motor/display outputs of the code-lock.
// master = stimulus side, slave = controller side.
interface motor_access_ctrl_if;

  logic [4:0] code;
  logic       submit;
  logic       stop;
  logic       motor_en;
  logic [2:0] status;
  logic [1:0] fail_cnt;
  logic       busy;

  modport master (
    output code,
    output submit,
    output stop,
    input  motor_en,
    input  status,
    input  fail_cnt,
    input  busy
  );

  modport slave (
    input  code,
    input  submit,
    input  stop,
    output motor_en,
    output status,
    output fail_cnt,
    output busy
  );

endinterface

// File: rtl/motor_access_ctrl_sync_edge.sv
// 2-FF synchronizer with registered level and rising-edge pulse.
// Third flop holds the previous level for edge detection.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/motor_access_ctrl.sv
// Code-lock sequencer: validate 3-of-5 code, run motor for a bounded time,
// count wrong attempts and impose lockout.
module motor_access_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W          = DEF_CNT_W,
  parameter logic [4:0]       KEY            = DEF_KEY,
  parameter logic [CNT_W-1:0] RUN_CYCLES     = DEF_RUN_CYCLES,
  parameter logic [CNT_W-1:0] DENY_CYCLES    = DEF_DENY_CYCLES,
  parameter logic [CNT_W-1:0] LOCKOUT_CYCLES = DEF_LOCK_CYCLES,
  parameter logic [1:0]       MAX_FAILS      = DEF_MAX_FAILS
) (
  input logic                clk,
  input logic                rst_n,
  motor_access_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] RUN_LD  = RUN_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] DENY_LD = DENY_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] LOCK_LD = LOCKOUT_CYCLES - 1'b1;

  logic sub_rise;
  logic sub_lvl_unused;
  logic stop_lvl;
  logic stop_rise_unused;

  sync_edge u_sub (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.submit),
    .level (sub_lvl_unused),
    .rise  (sub_rise)
  );

  sync_edge u_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.stop),
    .level (stop_lvl),
    .rise  (stop_rise_unused)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       fail_q, fail_d;
  logic [4:0]       code_q, code_d;
  logic             motor_en_q, motor_en_d;
  logic             busy_q, busy_d;

  logic       wt_ok;
  logic       key_hit;
  logic       lock_hit;
  logic [2:0] fail_inc;
  logic       tmr_zero;

  always_comb begin
    wt_ok    = is_3of5(code_q);
    key_hit  = wt_ok && (code_q == KEY);
    fail_inc = {1'b0, fail_q} + 3'd1;
    lock_hit = wt_ok && !key_hit &&
               (fail_inc == {1'b0, MAX_FAILS});
    tmr_zero = (timer_q == '0);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sub_rise) begin
          code_d  = bus.code;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        unique case (1'b1)
          !wt_ok: begin
            state_d = ST_ERR;
            timer_d = DENY_LD;
          end
          key_hit: begin
            state_d = ST_RUN;
            timer_d = RUN_LD;
            fail_d  = '0;
          end
          lock_hit: begin
            state_d = ST_LOCK;
            timer_d = LOCK_LD;
            fail_d  = MAX_FAILS;
          end
          default: begin
            state_d = ST_DENY;
            timer_d = DENY_LD;
            fail_d  = fail_inc[1:0];
          end
        endcase
      end
      // stop wins over expiry; both land in IDLE
      ST_RUN: begin
        if (stop_lvl || tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_DENY, ST_ERR: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LOCK: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    motor_en_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      fail_q     <= '0;
      code_q     <= '0;
      motor_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      motor_en_q <= motor_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.motor_en = motor_en_q;
  assign bus.status   = state_q;
  assign bus.fail_cnt = fail_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/motor_access_ctrl.md
# motor_access_ctrl

Sequencing controller for the motor code-lock path. Samples the 5-bit switch code on a debounced submit strobe and validates it as a 3-of-5 code. Matches it against a programmed key and, on success, enables the AC motor for a bounded run time. Tracks failed attempts and imposes a lockout after repeated failures. Sits between the switch/button inputs and the motor driver and display decoder; its `status` output selects the display message.

## Interface
- `KEY`, 5'b10101: accepted code.
- `RUN_CYCLES`, 24'd1_000_000: motor-on duration, in clk cycles.
- `DENY_CYCLES`, 24'd100_000: duration of the DENY/ERR indication.
- `LOCKOUT_CYCLES`, 24'd5_000_000: lockout duration.
- `MAX_FAILS`, 2'd3: wrong-code count that triggers lockout; range 1..3.
- `CNT_W`, 24: timer width; all `*_CYCLES` values are ≥1 and < 2^CNT_W.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `code` in 5: switch code; asynchronous, quasi-static.
- `submit` in 1: button, asynchronous; the rising edge requests a check.
- `stop` in 1: button, asynchronous; a high level aborts RUN.
- `motor_en` out 1: motor drive enable.
- `status` out 3: IDLE=0, CHECK=1, RUN=2, DENY=3, ERR=4, LOCK=5.
- `fail_cnt` out 2: consecutive wrong valid codes.
- `busy` out 1: high in any state except IDLE.

## Operation
- `submit` and `stop` each pass through a 2-FF synchronizer. `submit` additionally gets a rising-edge detector, so one pulse is produced per press.
- All outputs are registered or decoded from registered state (Moore).
- Reset values: state IDLE, `motor_en`=0, `status`=0, `fail_cnt`=0, `busy`=0, timer=0.
- IDLE: on a submit pulse, latch `code` into `code_q` and go to CHECK.
- CHECK (1 cycle): decided in priority order:
  - `code_q` popcount ≠ 3 → ERR; `fail_cnt` is unchanged.
  - `code_q`==KEY → RUN, `fail_cnt`←0, timer←RUN_CYCLES-1.
  - Otherwise, if `fail_cnt`+1 == MAX_FAILS → LOCK, timer←LOCKOUT_CYCLES-1, `fail_cnt`←MAX_FAILS.
  - Otherwise → DENY, `fail_cnt`←`fail_cnt`+1, timer←DENY_CYCLES-1.
- ERR: timer←DENY_CYCLES-1 on entry; behaves like DENY.
- RUN: `motor_en`=1.
  - Synced `stop`=1 → IDLE on the next edge. Stop has priority over timer expiry in the same cycle.
  - Timer==0 → IDLE. Otherwise the timer decrements.
- DENY/ERR: when the timer reaches 0 → IDLE; otherwise decrement.
- LOCK: when the timer reaches 0 → IDLE and `fail_cnt`←0; otherwise decrement.
- Submit pulses arriving outside IDLE are discarded and never queued.
- `stop` outside RUN has no effect.
- `code` changing after the latch has no effect on the current check.
- Timer arithmetic is unsigned CNT_W bits. It never wraps because it is only decremented while nonzero.
- Reset mid-operation (any state): outputs return to reset values within the same asynchronous assertion; `fail_cnt` is cleared.

## Timing
- Submit latency, counting from the first clk edge that samples `submit`=1:
  - Edge 3: state=CHECK and `code_q` latched.
  - Edge 4: state=RUN/DENY/ERR/LOCK.
  - `motor_en` rises after edge 4.
- Durations:
  - `motor_en` stays high for exactly RUN_CYCLES cycles if not stopped.
  - DENY/ERR lasts DENY_CYCLES cycles; LOCK lasts LOCKOUT_CYCLES cycles.
- Stop latency: `motor_en` falls 3 edges after the first edge sampling `stop`=1.
- Back-to-back: a new submit is accepted only after the return to IDLE (busy=0). This means at least 1 IDLE cycle between attempts.
- `submit` held high gives a single attempt; a release and new press are required for the next.

## Structure
- Package `motor_ctrl_pkg` holds:
  - the state/status enum (3-bit) and its encodings;
  - the `is_3of5(logic [4:0])` popcount function;
  - default timing constants.
- Sub-module `sync_edge`: 2-FF synchronizer with registered level output and a rising-edge pulse output, async active-low reset. Instantiated for `submit` and `stop` (only the level output is used for stop).
- Top level: state register, timer, `fail_cnt`, `code_q`, output decode.

## Test plan
Parameters: RUN_CYCLES=8, DENY_CYCLES=4, LOCKOUT_CYCLES=16, MAX_FAILS=3.

- Correct code: code=10101, submit pulse → `motor_en` rises after edge 4, stays high 8 cycles; status=2 then 0; `fail_cnt`=0.
- Wrong valid code: code=00111 submitted → status=3 for 4 cycles, `fail_cnt`=1, `motor_en`=0.
- Lockout: three submissions of 01110 → `fail_cnt` 1, 2, then status=5 for 16 cycles.
  - A press of 10101 during LOCK is ignored; `motor_en` stays 0.
  - After LOCK, `fail_cnt`=0.
- Invalid weight: code=11111 or 00001 → status=4 for 4 cycles; `fail_cnt` unchanged (e.g. stays 2).
- Stop: correct code, assert `stop` at cycle 3 of RUN → `motor_en` falls 3 edges later; status=0.
  - Stop and timer expiry in the same cycle → IDLE, with no glitch.
- Reset: `rst_n`=0 mid-RUN with `fail_cnt`=2 → `motor_en`=0, status=0, `fail_cnt`=0 immediately, without waiting for a clk edge.
